// File: rtl/ahb_mux_dphase_pkg.sv
// Shared types for the AHB data-phase response mux: error FSM states and
// the HRESP encodings it drives.
package AHB_package;

  typedef enum logic [1:0] {
    DPH_IDLE = 2'd0,
    DPH_ERR1 = 2'd1,
    DPH_ERR2 = 2'd2
  } dph_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/ahb_mux_dphase_onehot.sv
// One-hot checker: flags a vector with exactly one bit set and returns the
// position of that bit.
module ahb_onehot_chk #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             is_onehot,
  output logic [IDX_W-1:0] index
);

  logic [4:0] ones;

  always_comb begin
    ones  = '0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + 5'(vec[i]);
      if (vec[i]) index = IDX_W'(i);
    end
    is_onehot = (ones == 5'd1);
  end

endmodule

// File: rtl/ahb_mux_dphase.sv
// AHB data-phase response multiplexer with a built-in default slave that
// answers illegal (zero or multi-hot) selects with a two-cycle ERROR.
//
// state    | meaning
// ---------+----------------------------------------------------------
// DPH_IDLE | forward selected channel, or zero-wait OKAY if none
// DPH_ERR1 | first ERROR cycle, hready_out low
// DPH_ERR2 | second ERROR cycle, hready_out high, next transfer accepted
module ahb_mux_dphase
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int PAYLOAD     = 34,
  parameter int READY_BIT   = 32,
  parameter int RESP_BIT    = 33,
  parameter int CNT_W       = 8
) (
  input  logic                                hclk,
  input  logic                                hreset_n,
  input  logic [CHANNEL_NUM-1:0]              sel,
  input  logic                                htrans_valid,
  input  logic                                hready,
  input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in,
  output logic [PAYLOAD-1:0]                  payload_out,
  output logic [CHANNEL_NUM-1:0]              dphase_sel,
  output logic                                sel_err,
  output logic [CNT_W-1:0]                    err_cnt
);

  localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  dph_state_e       state, state_nxt;
  logic             sel_onehot, dph_onehot;
  logic [IDX_W-1:0] sel_idx, dph_idx;
  logic             accept, illegal;

  ahb_onehot_chk #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_sel_chk (
    .vec       (sel),
    .is_onehot (sel_onehot),
    .index     (sel_idx)
  );

  ahb_onehot_chk #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_dph_chk (
    .vec       (dphase_sel),
    .is_onehot (dph_onehot),
    .index     (dph_idx)
  );

  assign accept  = hready & htrans_valid;
  assign illegal = accept & ~sel_onehot;
  assign sel_err = (state != DPH_IDLE);

  // ERR1 drives hready_out low itself, so it must advance without waiting on hready
  always_comb begin
    state_nxt = state;
    case (state)
      DPH_ERR1: state_nxt = DPH_ERR2;
      DPH_ERR2: if (hready) state_nxt = illegal ? DPH_ERR1 : DPH_IDLE;
      DPH_IDLE: if (illegal) state_nxt = DPH_ERR1;
      default:  state_nxt = DPH_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state      <= DPH_IDLE;
      dphase_sel <= '0;
      err_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (hready) begin
        dphase_sel <= (accept && sel_onehot) ? sel : '0;
        if (illegal && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    payload_out = '0;
    case (state)
      DPH_ERR1: payload_out[RESP_BIT] = RESP_ERR;
      DPH_ERR2: begin
        payload_out[RESP_BIT]  = RESP_ERR;
        payload_out[READY_BIT] = 1'b1;
      end
      default: begin
        if (dph_onehot) begin
          payload_out = payload_in[dph_idx];
        end else begin
          payload_out[RESP_BIT]  = RESP_OKAY;
          payload_out[READY_BIT] = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_mux_dphase.sv
// Scoreboard bench for ahb_mux_dphase (2 channels, 2-bit error counter),
// with hready fed back from payload_out like a real bus.
module tb_ahb_mux_dphase;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic [1:0]       sel;
  logic             htrans_valid;
  logic             hready;
  logic [1:0][33:0] payload_in;
  logic [33:0]      payload_out;
  logic [1:0]       dphase_sel;
  logic             sel_err;
  logic [1:0]       err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [33:0] pay;
    logic [1:0]  dsel;
    logic        err;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sbq[$];

  int         m_state;
  logic [1:0] m_dsel;
  logic [1:0] m_cnt;

  always #5 hclk = ~hclk;

  assign hready = payload_out[32];

  ahb_mux_dphase #(
    .CHANNEL_NUM (2),
    .PAYLOAD     (34),
    .READY_BIT   (32),
    .RESP_BIT    (33),
    .CNT_W       (2)
  ) dut (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .sel          (sel),
    .htrans_valid (htrans_valid),
    .hready       (hready),
    .payload_in   (payload_in),
    .payload_out  (payload_out),
    .dphase_sel   (dphase_sel),
    .sel_err      (sel_err),
    .err_cnt      (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [33:0] mpay(input int st, input logic [1:0] ds,
                                       input logic [33:0] p0, input logic [33:0] p1);
    if (st == 1) return 34'h2_0000_0000;
    if (st == 2) return 34'h3_0000_0000;
    if (ds == 2'b01) return p0;
    if (ds == 2'b10) return p1;
    return 34'h1_0000_0000;
  endfunction

  task automatic drive(input logic [1:0] s, input logic v,
                       input logic [33:0] p0, input logic [33:0] p1);
    exp_t        e, g;
    logic [33:0] cur;
    logic        hr, legal, acc;
    int          ns;
    sel = s; htrans_valid = v; payload_in[0] = p0; payload_in[1] = p1;
    cur   = mpay(m_state, m_dsel, p0, p1);
    hr    = cur[32];
    legal = (s == 2'b01) || (s == 2'b10);
    acc   = hr & v;
    if (m_state == 1)  ns = 2;
    else if (hr)       ns = (acc && !legal) ? 1 : 0;
    else               ns = m_state;
    if (hr) begin
      m_dsel = (acc && legal) ? s : 2'b00;
      if (acc && !legal && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
    end
    m_state = ns;
    e.pay  = mpay(m_state, m_dsel, p0, p1);
    e.dsel = m_dsel;
    e.err  = (m_state != 0);
    e.cnt  = m_cnt;
    sbq.push_back(e);
    @(posedge hclk); #1;
    g = sbq.pop_front();
    chk("payload_out", 64'(payload_out), 64'(g.pay));
    chk("dphase_sel",  64'(dphase_sel),  64'(g.dsel));
    chk("sel_err",     64'(sel_err),     64'(g.err));
    chk("err_cnt",     64'(err_cnt),     64'(g.cnt));
  endtask

  task automatic do_reset();
    sel = 2'b00; htrans_valid = 1'b0;
    hreset_n = 1'b0;
    #2;
    chk("rst_dphase_sel",  64'(dphase_sel),  64'(0));
    chk("rst_sel_err",     64'(sel_err),     64'(0));
    chk("rst_payload_out", 64'(payload_out), 64'h1_0000_0000);
    chk("rst_err_cnt",     64'(err_cnt),     64'(0));
    m_state = 0; m_dsel = 2'b00; m_cnt = 2'b00;
    @(negedge hclk); hreset_n = 1'b1;
    @(posedge hclk); #1;
  endtask

  function automatic logic [33:0] rnd_pay(input int ready_pct);
    logic [33:0] p;
    p[31:0] = $urandom();
    p[33]   = 1'($urandom_range(0, 1));
    p[32]   = ($urandom_range(0, 99) < ready_pct);
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [33:0] pa, pb;
    logic [1:0]  exp_cnt [5];
    int          err_cycles;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    payload_in = '0;
    do_reset();

    // legal select of channel 1
    pa = 34'h1_1111_0000;
    drive(2'b10, 1'b1, pa, 34'h3_0000_BEEF);
    chk("sel10_payload", 64'(payload_out), 64'h3_0000_BEEF);
    chk("sel10_dsel",    64'(dphase_sel),  64'(2'b10));
    drive(2'b00, 1'b0, pa, 34'h3_0000_BEEF);

    // multi-hot select -> ERR1 then ERR2
    drive(2'b11, 1'b1, pa, 34'h1_0000_0001);
    chk("err1_payload", 64'(payload_out), 64'h2_0000_0000);
    drive(2'b00, 1'b0, pa, 34'h1_0000_0001);
    chk("err2_payload", 64'(payload_out), 64'h3_0000_0000);
    chk("err2_cnt",     64'(err_cnt),     64'(1));
    drive(2'b00, 1'b0, pa, 34'h1_0000_0001);

    // channel 0 stalls three cycles while sel toggles
    pb = 34'h0_CAFE_0000;
    drive(2'b01, 1'b1, pb, 34'h1_2222_0000);
    for (int i = 0; i < 3; i++) begin
      drive((i % 2 == 0) ? 2'b10 : 2'b11, 1'b1, pb, 34'h1_2222_0000);
      chk("stall_hold_dsel", 64'(dphase_sel), 64'(2'b01));
    end
    drive(2'b10, 1'b1, 34'h1_CAFE_0001, 34'h1_2222_0000);
    chk("stall_release_dsel", 64'(dphase_sel), 64'(2'b10));

    // back-to-back illegal transfers: ERR2 goes straight back to ERR1
    err_cycles = 0;
    drive(2'b11, 1'b1, pa, 34'h1_0000_0002); err_cycles += int'(sel_err);
    drive(2'b00, 1'b0, pa, 34'h1_0000_0002); err_cycles += int'(sel_err);
    drive(2'b00, 1'b1, pa, 34'h1_0000_0002); err_cycles += int'(sel_err);
    chk("b2b_err1_payload", 64'(payload_out), 64'h2_0000_0000);
    drive(2'b00, 1'b0, pa, 34'h1_0000_0002); err_cycles += int'(sel_err);
    chk("b2b_err_cycles", 64'(err_cycles), 64'(4));
    drive(2'b00, 1'b0, pa, 34'h1_0000_0002);
    chk("b2b_idle_sel_err", 64'(sel_err), 64'(0));

    // saturation of the 2-bit counter from a clean start
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 1'b1, pa, pa);
      chk("sat_err_cnt", 64'(err_cnt), 64'(exp_cnt[i]));
      drive(2'b00, 1'b0, pa, pa);
    end
    drive(2'b00, 1'b0, pa, pa);

    // reset while ERR1 is being driven
    drive(2'b00, 1'b1, pa, pa);
    chk("pre_rst_sel_err", 64'(sel_err), 64'(1));
    hreset_n = 1'b0;
    #1;
    chk("midrst_sel_err",  64'(sel_err),     64'(0));
    chk("midrst_payload",  64'(payload_out), 64'h1_0000_0000);
    chk("midrst_dsel",     64'(dphase_sel),  64'(0));
    do_reset();
    drive(2'b00, 1'b0, pa, pa);
    chk("post_rst_cnt", 64'(err_cnt), 64'(0));

    // random traffic
    for (int i = 0; i < 60; i++)
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            rnd_pay(75), rnd_pay(75));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mux_dphase.md
AHB_MUX_DPHASE -- requirements
Module: ahb_mux_dphase

Interface
REQ-001 Parameter CHANNEL_NUM, default 2: number of response channels; legal range 1..16.
REQ-002 Parameter PAYLOAD, default 34: per-channel response payload width (hrdata 32 + hready_out + hresp).
REQ-003 Parameter READY_BIT, default 32: payload bit index carrying hready_out.
REQ-004 Parameter RESP_BIT, default 33: payload bit index carrying hresp (1 = ERROR).
REQ-005 Parameter CNT_W, default 8: width of error counter.
REQ-006 hclk  in  1  single AHB clock; all state on rising edge.
REQ-007 hreset_n  in  1  reset, asynchronous, active-low.
REQ-008 sel  in  CHANNEL_NUM  address-phase one-hot channel select from decoder.
REQ-009 htrans_valid  in  1  address phase carries NONSEQ/SEQ transfer.
REQ-010 hready  in  1  bus-level HREADY (fed back from payload_out[READY_BIT]).
REQ-011 payload_in  in  CHANNEL_NUM x PAYLOAD  packed response payload per channel.
REQ-012 payload_out  out  PAYLOAD  selected data-phase response.
REQ-013 dphase_sel  out  CHANNEL_NUM  registered data-phase one-hot select.
REQ-014 sel_err  out  1  high while default-slave ERROR response is driven.
REQ-015 err_cnt  out  CNT_W  count of illegal-select transfers, saturating.

Function
REQ-016 Address-phase accept event A = hready & htrans_valid; idle event I = hready & ~htrans_valid.
REQ-017 On A with sel one-hot, dphase_sel SHALL load sel next cycle.
REQ-018 On I, dphase_sel SHALL load all-zero next cycle.
REQ-019 On A with sel zero or multi-hot (illegal), dphase_sel SHALL load zero and FSM SHALL enter ERR1.
REQ-020 When hready=0, dphase_sel and FSM SHALL hold.
REQ-021 FSM states IDLE, ERR1, ERR2; ERR1->ERR2 unconditionally; ERR2->ERR1 on illegal A, else IDLE; IDLE->ERR1 on illegal A.
REQ-022 ERR1: payload_out all-zero except RESP_BIT=1, READY_BIT=0; sel_err=1.
REQ-023 ERR2: payload_out all-zero except RESP_BIT=1, READY_BIT=1; sel_err=1.
REQ-024 IDLE with dphase_sel one-hot: payload_out = payload_in[index of dphase_sel], combinational, zero added latency.
REQ-025 IDLE with dphase_sel zero: payload_out all-zero except READY_BIT=1 (zero-wait OKAY).
REQ-026 err_cnt SHALL increment by 1 on each illegal A, saturating at 2^CNT_W-1, never wrapping.
REQ-027 Selected channel stalling (READY_BIT=0) SHALL extend data phase; next sel sampled only when hready=1.
REQ-028 sel is not registered outside A; sel changes while hready=0 SHALL have no effect.

Reset
REQ-029 hreset_n low SHALL asynchronously force dphase_sel=0, FSM=IDLE, err_cnt=0, sel_err=0.
REQ-030 payload_out during reset SHALL equal REQ-025 value (READY_BIT=1, others 0).
REQ-031 Reset asserted mid-ERR1/ERR2 SHALL abort the error response; no counter change on release.

Structure
REQ-032 FSM state enum (dph_state_e) and ERR/OKAY resp constants SHALL reside in AHB_package.
REQ-033 One sub-module ahb_onehot_chk (is_onehot, index output) SHALL be instantiated for sel and dphase_sel decoding.

Verification
REQ-034 CHANNEL_NUM=2: A with sel=2'b10, payload_in[1]=0x3_0000_BEEF -> next cycle dphase_sel=2'b10, payload_out=0x3_0000_BEEF.
REQ-035 A with sel=2'b11 -> cycle+1 payload_out=0x2_0000_0000 (ERR1), cycle+2 0x3_0000_0000 (ERR2), err_cnt=1.
REQ-036 Channel 0 selected, payload_in[0][32]=0 for 3 cycles, sel toggled -> dphase_sel stays 2'b01 until READY_BIT=1.
REQ-037 CNT_W=2, 5 illegal A events -> err_cnt sequence 1,2,3,3,3.
REQ-038 hreset_n low during ERR1 -> same cycle sel_err=0, payload_out=0x1_0000_0000, dphase_sel=0.
REQ-039 Back-to-back illegal A in ERR2 -> ERR2->ERR1 directly, sel_err continuously 1 for 4 cycles.
